// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: two-requester round-robin front end for one shared,
// two-cycle FP adder. Accepted operand pairs are registered onto add_a/add_b,
// tracked through a 3-stage {valid, tag} issue pipeline, and the adder result
// is steered back to the requester that issued it, exactly 3 cycles after
// acceptance.
// Optional build macro: FP_ADD_ARBITER_STATS_EN adds per-requester 16-bit
// saturating response counters (cnt0, cnt1).
module fp_add_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_result,
  input  logic        add_overflow,
  input  logic        add_underflow,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_data,
  output logic        resp_ovf,
  output logic        resp_unf,
  output logic [1:0]  inflight
`ifdef FP_ADD_ARBITER_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  // Number of occupied issue-pipeline stages.
  function automatic logic [1:0] count_valid(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  logic       ptr_r;      // requester favoured when both are valid
  logic [2:0] vld_r;      // issue pipeline valid bits, [2] is oldest
  logic [2:0] tag_r;      // issue pipeline requester index per stage
  logic       grant0_s;
  logic       grant1_s;
  logic       xfer_s;
  logic       gidx_s;

  // Round-robin grant; nothing is granted while reset is held.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (ptr_r) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign xfer_s     = grant0_s | grant1_s;
  assign gidx_s     = grant1_s;
  assign inflight   = count_valid(vld_r);

  // Pointer update, operand register and issue pipeline advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
      vld_r <= 3'b000;
      tag_r <= 3'b000;
      add_a <= 32'h0000_0000;
      add_b <= 32'h0000_0000;
    end else begin
      vld_r <= {vld_r[1:0], xfer_s};
      tag_r <= {tag_r[1:0], gidx_s};
      if (xfer_s) begin
        ptr_r <= ~gidx_s;
        add_a <= gidx_s ? req1_a : req0_a;
        add_b <= gidx_s ? req1_b : req0_b;
      end
    end
  end

  // Registered response steering; outputs are zero when no response is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= 32'h0000_0000;
      resp_ovf    <= 1'b0;
      resp_unf    <= 1'b0;
    end else begin
      resp0_valid <= vld_r[2] & ~tag_r[2];
      resp1_valid <= vld_r[2] &  tag_r[2];
      resp_data   <= vld_r[2] ? add_result    : 32'h0000_0000;
      resp_ovf    <= vld_r[2] ? add_overflow  : 1'b0;
      resp_unf    <= vld_r[2] ? add_underflow : 1'b0;
    end
  end

`ifdef FP_ADD_ARBITER_STATS_EN
  // Saturating increment for the response counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : (c + 16'h0001);
  endfunction

  // Per-requester delivered-response counters, updated with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 16'h0000;
      cnt1 <= 16'h0000;
    end else begin
      if (vld_r[2] && !tag_r[2]) begin
        cnt0 <= sat_inc(cnt0);
      end
      if (vld_r[2] && tag_r[2]) begin
        cnt1 <= sat_inc(cnt1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: a behavioural two-cycle FP adder,
// a reference grant/pointer model and a response scoreboard.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [31:0] add_a, add_b;
  logic [31:0] add_result;
  logic        add_overflow, add_underflow;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_data;
  logic        resp_ovf, resp_unf;
  logic [1:0]  inflight;
`ifdef FP_ADD_ARBITER_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  fp_add_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_overflow(add_overflow), .add_underflow(add_underflow),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_ovf(resp_ovf), .resp_unf(resp_unf),
    .inflight(inflight)
`ifdef FP_ADD_ARBITER_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // IEEE single add through real arithmetic, overflow clamped to infinity.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real      r;
    shortreal s;
    r = $bitstoshortreal(a) + $bitstoshortreal(b);
    if (r > 3.4028234663852886e38)  return 32'h7F80_0000;
    if (r < -3.4028234663852886e38) return 32'hFF80_0000;
    s = r;
    return $shortrealtobits(s);
  endfunction

  // Shared adder model: input register, then result register.
  logic [31:0] in_a_r, in_b_r, res_r;
  always @(posedge clk) begin
    in_a_r <= add_a;
    in_b_r <= add_b;
    res_r  <= fadd(in_a_r, in_b_r);
  end
  assign add_result    = res_r;
  assign add_overflow  = (res_r[30:23] == 8'hFF);
  assign add_underflow = (res_r[30:23] == 8'h00);

  typedef struct {
    logic        idx;
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic        ptr_m   = 1'b0;
  logic [31:0] exp_a_m = 32'h0;
  logic [31:0] exp_b_m = 32'h0;
  int          cnt_m0  = 0;
  int          cnt_m1  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic  e0, e1;
    int    n;
    exp_t  e;
    logic [31:0] s;
    if (!rst_n) begin
      q.delete();
      ptr_m   = 1'b0;
      exp_a_m = 32'h0;
      exp_b_m = 32'h0;
      cnt_m0  = 0;
      cnt_m1  = 0;
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_resp", {27'd0, resp0_valid, resp1_valid, resp_ovf, resp_unf, 1'b0} | resp_data, 32'd0);
      chk("rst_add_a", add_a, 32'd0);
      chk("rst_add_b", add_b, 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
    end else begin
      // responses
      chk("resp_both", 32'(resp0_valid & resp1_valid), 32'd0);
      if (resp0_valid || resp1_valid) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", 32'(resp1_valid), 32'(resp0_valid));
          chk("resp_unexpected_any", 32'd1, 32'd0 + 32'(q.size()));
        end else begin
          e = q.pop_front();
          chk("resp_idx", 32'(resp1_valid), 32'(e.idx));
          chk("resp_latency", 32'(cyc), 32'(e.due));
          chk("resp_data", resp_data, e.data);
          chk("resp_ovf", 32'(resp_ovf), 32'(e.ovf));
          chk("resp_unf", 32'(resp_unf), 32'(e.unf));
          if (e.idx) cnt_m1++; else cnt_m0++;
        end
      end else begin
        chk("idle_resp", resp_data | {30'd0, resp_ovf, resp_unf}, 32'd0);
        chk("resp_missing", 32'((q.size() > 0) && (q[0].due <= cyc)), 32'd0);
      end
`ifdef FP_ADD_ARBITER_STATS_EN
      chk("cnt0", 32'(cnt0), 32'(cnt_m0));
      chk("cnt1", 32'(cnt1), 32'(cnt_m1));
`endif
      // in-flight operations: accepted, response not yet delivered
      n = 0;
      foreach (q[i]) if (q[i].due > cyc) n++;
      chk("inflight", 32'(inflight), 32'(n));
      chk("add_a", add_a, exp_a_m);
      chk("add_b", add_b, exp_b_m);
      // grant
      e0 = 1'b0;
      e1 = 1'b0;
      if (req0_valid && req1_valid) begin
        if (ptr_m) e1 = 1'b1; else e0 = 1'b1;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
      chk("ready0", 32'(req0_ready), 32'(e0));
      chk("ready1", 32'(req1_ready), 32'(e1));
      if (e0 || e1) begin
        exp_a_m = e1 ? req1_a : req0_a;
        exp_b_m = e1 ? req1_b : req0_b;
        s       = fadd(exp_a_m, exp_b_m);
        e.idx   = e1;
        e.data  = s;
        e.ovf   = (s[30:23] == 8'hFF);
        e.unf   = (s[30:23] == 8'h00);
        e.due   = cyc + 4;
        q.push_back(e);
        ptr_m   = ~e1;
      end
    end
  end

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(112, 143)), 23'($urandom)};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single op on requester 0: 1.0 + 1.0 = 2.0
    drive(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0, 32'h0);
    idle(5);

    // both requesters contending for 6 cycles
    for (int i = 0; i < 6; i++) drive(1'b1, rnd_fp(), rnd_fp(), 1'b1, rnd_fp(), rnd_fp());
    idle(5);

    // requester 1 alone for 4 cycles
    for (int i = 0; i < 4; i++) drive(1'b0, rnd_fp(), rnd_fp(), 1'b1, rnd_fp(), rnd_fp());
    idle(5);

    // overflow to infinity, then exact cancellation to zero
    drive(1'b1, 32'h7F00_0000, 32'h7F00_0000, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h3F80_0000, 32'hBF80_0000);
    idle(5);

    // fill the pipeline, then reset with 3 operations in flight
    for (int i = 0; i < 4; i++) drive(1'b1, rnd_fp(), rnd_fp(), 1'b1, rnd_fp(), rnd_fp());
    chk("inflight_full", 32'(inflight), 32'd3);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // first edge after release accepts; pointer restarted at requester 0
    drive(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 32'h4000_0000);
    idle(6);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
